// File: rtl/frequency_measurement_scheduler.sv
// Measurement-cycle sequencer: clear analyzers, open a fixed window, drain results to the register file, raise irq.
// Optional FREQ_SCHED_SEQUENCE_EN appends a run sequence number as an extra register write.
module frequency_measurement_scheduler #(
    parameter int RESULTS_NUMBER = 6,
    parameter int WINDOW_CYCLES  = 100000000,
    parameter int SETTLE_CYCLES  = 2,
    parameter int WRITE_HOLD     = 4
) (
    input  logic        s00_axi_aclk,
    input  logic        s00_axi_aresetn,
    input  logic        start,
    input  logic        stop,
    input  logic        continuous,
    input  logic        irq_ack,
    input  logic [31:0] result_value,
    output logic        analyzer_enable,
    output logic        analyzer_clear_n,
    output logic [2:0]  result_index,
    output logic [1:0]  register_operation,
    output logic [7:0]  register_number,
    output logic [31:0] register_write,
    output logic        irq,
    output logic        busy
);

`ifdef FREQ_SCHED_SEQUENCE_EN
    localparam int NWORDS = RESULTS_NUMBER + 1;
`else
    localparam int NWORDS = RESULTS_NUMBER;
`endif
    localparam int CMAX = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam int HW   = $clog2(WRITE_HOLD);
    localparam int NWW  = $clog2(NWORDS + 1);

    localparam logic [CW-1:0]  WIN_LAST    = CW'(WINDOW_CYCLES - 1);
    localparam logic [CW-1:0]  SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [HW-1:0]  HOLD_LAST   = HW'(WRITE_HOLD - 1);
    localparam logic [HW-1:0]  HOLD_STROBE = HW'(1);
    localparam logic [NWW-1:0] WORD_LAST   = NWW'(NWORDS);
    localparam logic [NWW-1:0] WORD_RES    = NWW'(RESULTS_NUMBER);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CLEAR   = 3'd1;
    localparam logic [2:0] S_MEASURE = 3'd2;
    localparam logic [2:0] S_SETTLE  = 3'd3;
    localparam logic [2:0] S_DRAIN   = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic [NWW-1:0] word_q, word_d;
    logic [7:0]     num_q, num_d;
    logic [31:0]    data_q, data_d;
    logic           strobe;
    logic           is_result;
    logic [31:0]    wr_now;

    assign strobe    = (state_q == S_DRAIN) && (hold_q == HOLD_STROBE);
    assign is_result = (word_q <= WORD_RES);

`ifdef FREQ_SCHED_SEQUENCE_EN
    logic [31:0] seq_q, seq_d;
    // The extra slot carries the value the counter takes when this drain completes.
    assign wr_now = is_result ? result_value : seq_q + 32'd1;
`else
    assign wr_now = result_value;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        word_d  = word_q;
        num_d   = num_q;
        data_d  = data_q;
`ifdef FREQ_SCHED_SEQUENCE_EN
        seq_d   = seq_q;
`endif
        case (state_q)
            S_IDLE: if (start) state_d = S_CLEAR;
            S_CLEAR: begin
                state_d = S_MEASURE;
                cnt_d   = '0;
            end
            S_MEASURE: begin
                if (cnt_q == WIN_LAST) begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                    hold_d  = '0;
                    word_d  = NWW'(1);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DRAIN: begin
                if (strobe) begin
                    num_d  = 8'(word_q);
                    data_d = wr_now;
                end
                if (hold_q == HOLD_LAST) begin
                    hold_d = '0;
                    if (word_q == WORD_LAST) begin
                        state_d = S_DONE;
                        word_d  = '0;
`ifdef FREQ_SCHED_SEQUENCE_EN
                        seq_d   = seq_q + 32'd1;
`endif
                    end else begin
                        word_d = word_q + NWW'(1);
                    end
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            S_DONE: if (irq_ack) state_d = (continuous || start) ? S_CLEAR : S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (stop) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            hold_d  = '0;
            word_d  = '0;
        end
        // Held write outputs only live inside a drain; any exit wipes them.
        if (state_d != S_DRAIN) begin
            num_d  = '0;
            data_d = '0;
        end
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
            word_q  <= '0;
            num_q   <= '0;
            data_q  <= '0;
`ifdef FREQ_SCHED_SEQUENCE_EN
            seq_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            word_q  <= word_d;
            num_q   <= num_d;
            data_q  <= data_d;
`ifdef FREQ_SCHED_SEQUENCE_EN
            seq_q   <= seq_d;
`endif
        end
    end

    assign busy               = (state_q != S_IDLE);
    assign analyzer_clear_n   = (state_q != S_CLEAR);
    assign analyzer_enable    = (state_q == S_MEASURE);
    assign irq                = (state_q == S_DONE);
    assign result_index       = ((state_q == S_DRAIN) && is_result) ? 3'(word_q) : 3'd0;
    assign register_operation = strobe ? 2'd2 : 2'd0;
    assign register_number    = strobe ? 8'(word_q) : num_q;
    assign register_write     = strobe ? wr_now : data_q;

endmodule

// File: tb/tb_frequency_measurement_scheduler.sv
// Bench for frequency_measurement_scheduler: run-phase model (cycles since start) checked every cycle,
// directed scenarios with literal timing pins, then randomized start/stop/ack/reset traffic.
module tb_frequency_measurement_scheduler;
    localparam int W = 100, S = 2, H = 4, R = 6;
`ifdef FREQ_SCHED_SEQUENCE_EN
    localparam int NW = R + 1;
    localparam int IRQ_AT = 132;
`else
    localparam int NW = R;
    localparam int IRQ_AT = 128;
`endif
    localparam int D0    = W + S + 2;
    localparam int DONEP = D0 + NW * H;

    logic clk = 0, rstn = 0, start = 0, stop = 0, cont = 0, ack = 0;
    logic [31:0] rv = 0;
    logic        en, clr_n, irq, busy;
    logic [2:0]  idx;
    logic [1:0]  op;
    logic [7:0]  num;
    logic [31:0] wr;

    frequency_measurement_scheduler #(
        .RESULTS_NUMBER(R), .WINDOW_CYCLES(W), .SETTLE_CYCLES(S), .WRITE_HOLD(H)
    ) dut (
        .s00_axi_aclk(clk), .s00_axi_aresetn(rstn), .start(start), .stop(stop),
        .continuous(cont), .irq_ack(ack), .result_value(rv),
        .analyzer_enable(en), .analyzer_clear_n(clr_n), .result_index(idx),
        .register_operation(op), .register_number(num), .register_write(wr),
        .irq(irq), .busy(busy)
    );

    always #5 clk = ~clk;

    // Analyzer model: result mux output valid one cycle after the index changes.
    always @(posedge clk) rv <= 32'h100 + 32'(idx);

    int ncmp = 0, nerr = 0;
    int cyc = 0;
    int p = 0;          // 0 = idle, else cycles since the run's start was sampled
    logic [31:0] seq = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s cyc=%0d got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] wdata(input int k);
        return (k <= R) ? 32'h100 + 32'(k) : seq + 32'd1;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
        if (!rstn) begin
            p = 0;
            seq = 0;
        end else if (stop) p = 0;
        else if (p == 0) begin
            if (start) p = 1;
        end else if (p == DONEP) begin
            if (ack) p = (cont || start) ? 1 : 0;
        end else begin
            p++;
            if (p == DONEP) seq++;
        end
    end

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            begin
                automatic logic [2:0]  e_idx = 0;
                automatic logic [1:0]  e_op = 0;
                automatic logic [7:0]  e_num = 0;
                automatic logic [31:0] e_wr = 0;
                if (p >= D0 && p < DONEP) begin
                    automatic int slot = (p - D0) / H;
                    automatic int off  = (p - D0) % H;
                    automatic int k    = slot + 1;
                    e_idx = (k <= R) ? 3'(k) : 3'd0;
                    if (off >= 1) begin
                        e_num = 8'(k);
                        e_wr  = wdata(k);
                    end else if (slot > 0) begin
                        e_num = 8'(k - 1);
                        e_wr  = wdata(k - 1);
                    end
                    if (off == 1) e_op = 2'd2;
                end
                chk("busy", 32'(busy), 32'(p != 0));
                chk("clear_n", 32'(clr_n), 32'(p != 1));
                chk("enable", 32'(en), 32'(p >= 2 && p <= W + 1));
                chk("irq", 32'(irq), 32'(p == DONEP));
                chk("result_index", 32'(idx), 32'(e_idx));
                chk("reg_op", 32'(op), 32'(e_op));
                chk("reg_num", 32'(num), 32'(e_num));
                chk("reg_write", wr, e_wr);
            end
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    initial begin
        int s;
        repeat (3) @(negedge clk);
        rstn = 1;
        repeat (20) @(negedge clk);
        chk("idle_busy_pin", 32'(busy), 32'd0);
        chk("idle_clear_n_pin", 32'(clr_n), 32'd1);

        // Single run with literal timing pins
        s = cyc;
        pulse_start();
        chk("clear_cycle1_pin", 32'(clr_n), 32'd0);
        wait_until(s + 2);
        chk("enable_cycle2_pin", 32'(en), 32'd1);
        wait_until(s + 101);
        chk("enable_cycle101_pin", 32'(en), 32'd1);
        wait_until(s + 102);
        chk("enable_cycle102_pin", 32'(en), 32'd0);
        wait_until(s + 105);
        chk("strobe1_op_pin", 32'(op), 32'd2);
        chk("strobe1_num_pin", 32'(num), 32'd1);
        chk("strobe1_data_pin", wr, 32'h101);
        wait_until(s + 125);
        chk("strobe6_data_pin", wr, 32'h106);
`ifdef FREQ_SCHED_SEQUENCE_EN
        wait_until(s + 129);
        chk("seq_reg_pin", 32'(num), 32'd7);
        chk("seq_val_pin", wr, 32'd1);
`endif
        wait_until(s + IRQ_AT - 1);
        chk("irq_early_pin", 32'(irq), 32'd0);
        wait_until(s + IRQ_AT);
        chk("irq_time_pin", 32'(irq), 32'd1);
        wait_until(s + 140);
        ack = 1;
        @(negedge clk);
        ack = 0;
        chk("ack_idle_pin", 32'(busy), 32'd0);
        repeat (5) @(negedge clk);

        // Continuous: ack restarts into CLEAR
        cont = 1;
        s = cyc;
        pulse_start();
        wait_until(s + 140);
        ack = 1;
        @(negedge clk);
        ack = 0;
        chk("cont_irq_drop_pin", 32'(irq), 32'd0);
        chk("cont_clear_pin", 32'(clr_n), 32'd0);
        cont = 0;
        wait_until(s + 140 + 105);
        chk("cont_strobe_pin", 32'(num), 32'd1);
`ifdef FREQ_SCHED_SEQUENCE_EN
        wait_until(s + 140 + 129);
        chk("seq_val2_pin", wr, 32'd3);
`endif
        wait_until(s + 140 + IRQ_AT + 3);
        ack = 1;
        @(negedge clk);
        ack = 0;
        repeat (3) @(negedge clk);

        // Stop after the third strobe
        s = cyc;
        pulse_start();
        wait_until(s + 114);
        stop = 1;
        @(negedge clk);
        stop = 0;
        chk("stop_busy_pin", 32'(busy), 32'd0);
        repeat (30) @(negedge clk);
        chk("stop_no_irq_pin", 32'(irq), 32'd0);

        // Ignored inputs: start mid-window, ack in idle, start+stop in idle
        s = cyc;
        pulse_start();
        wait_until(s + 50);
        pulse_start();
        wait_until(s + 60);
        stop = 1;
        @(negedge clk);
        stop = 0;
        ack = 1;
        @(negedge clk);
        ack = 0;
        start = 1;
        stop = 1;
        @(negedge clk);
        start = 0;
        stop = 0;
        chk("start_stop_idle_pin", 32'(busy), 32'd0);
        repeat (5) @(negedge clk);

        // Randomized traffic
        for (int i = 0; i < 6000; i++) begin
            stop  = ($urandom_range(0, 399) == 0);
            start = (p == 0) ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 59) == 0);
            ack   = (p == DONEP) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 49) == 0) cont = $urandom_range(0, 1);
            rstn  = !(i == 3000 || i == 4711);
            @(negedge clk);
        end
        start = 0;
        stop = 0;
        ack = 0;
        rstn = 1;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
